actuator_power_arbiter: RTL and testbench



---
 rtl/actuator_power_arbiter_if.sv | 26 ++
 rtl/actuator_power_arbiter.sv | 139 +++++++++++++
 tb/tb_actuator_power_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/actuator_power_arbiter_if.sv
// Request/grant bundle between the sequencing FSM and the power arbiter.
interface actuator_power_arbiter_if #(
  parameter int SPEED_W = 11
);
  logic               heater_req;
  logic               motor_req;
  logic [SPEED_W-1:0] motor_speed_req;
  logic               fault;
  logic               heater_grant;
  logic               motor_grant;
  logic [SPEED_W-1:0] motor_speed_out;
  logic [1:0]         owner;
  logic               busy;

  // Requester side (sequencing FSM)
  modport master (
    output heater_req, motor_req, motor_speed_req, fault,
    input  heater_grant, motor_grant, motor_speed_out, owner, busy
  );

  // Arbiter side
  modport slave (
    input  heater_req, motor_req, motor_speed_req, fault,
    output heater_grant, motor_grant, motor_speed_out, owner, busy
  );
endinterface

// File: rtl/actuator_power_arbiter.sv
// Heater / drum motor supply arbiter: fair grant, minimum on-time,
// contested pre-emption, dead time between loads, and drum speed ramp.
module actuator_power_arbiter #(
  parameter int SPEED_W     = 11,
  parameter int CNT_W       = 16,
  parameter int MIN_ON      = 16,
  parameter int MAX_HOLD    = 1024,
  parameter int DEAD_CYCLES = 8,
  parameter int RAMP_STEP   = 50,
  parameter int RAMP_DIV    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  actuator_power_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0]   MIN_ON_C  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0]   MAX_HLD_C = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]   DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DIV_LAST  = CNT_W'(RAMP_DIV - 1);
  localparam logic [SPEED_W-1:0] STEP      = SPEED_W'(RAMP_STEP);

  typedef enum logic [2:0] {
    S_IDLE, S_HEAT, S_MOTOR, S_RAMP_DOWN, S_DEAD
  } state_t;

  state_t             state, state_nxt;
  logic               last_motor;          // 1: motor held the supply last
  logic [CNT_W-1:0]   hold_cnt, dead_cnt, ramp_cnt;
  logic [SPEED_W-1:0] speed_q, target, speed_step;
  logic               heater_q, motor_q, busy_q;
  logic [1:0]         owner_q, owner_nxt;
  logic               in_motor, nxt_motor, ramp_tick, hold_ok, hold_max;

  assign bus.heater_grant    = heater_q;
  assign bus.motor_grant     = motor_q;
  assign bus.motor_speed_out = speed_q;
  assign bus.owner           = owner_q;
  assign bus.busy            = busy_q;

  // Ramp step toward the current target, clamped so it never overshoots
  always_comb begin
    in_motor   = (state == S_MOTOR) || (state == S_RAMP_DOWN);
    ramp_tick  = in_motor && (ramp_cnt == DIV_LAST);
    target     = (state == S_MOTOR) ? bus.motor_speed_req : '0;
    speed_step = speed_q;
    if (target >= speed_q) begin
      if ((target - speed_q) <= STEP) speed_step = target;
      else                            speed_step = speed_q + STEP;
    end else begin
      if ((speed_q - target) <= STEP) speed_step = target;
      else                            speed_step = speed_q - STEP;
    end
  end

  // Next-state: arbitration in IDLE, release rules while holding
  always_comb begin
    state_nxt = state;
    hold_ok   = hold_cnt >= MIN_ON_C;
    hold_max  = hold_cnt >= MAX_HLD_C;
    case (state)
      S_IDLE: begin
        if (!bus.fault) begin
          if (bus.heater_req && bus.motor_req)
            state_nxt = last_motor ? S_HEAT : S_MOTOR;
          else if (bus.heater_req) state_nxt = S_HEAT;
          else if (bus.motor_req)  state_nxt = S_MOTOR;
        end
      end
      S_HEAT: begin
        if (bus.fault) state_nxt = S_DEAD;
        else if (hold_ok && (!bus.heater_req || (bus.motor_req && hold_max)))
          state_nxt = S_DEAD;
      end
      S_MOTOR: begin
        if (bus.fault) state_nxt = S_RAMP_DOWN;
        else if (hold_ok && (!bus.motor_req || (bus.heater_req && hold_max)))
          state_nxt = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: if (speed_q == '0) state_nxt = S_DEAD;
      S_DEAD:      if (dead_cnt >= DEAD_LAST) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    nxt_motor = (state_nxt == S_MOTOR) || (state_nxt == S_RAMP_DOWN);
    case (state_nxt)
      S_IDLE:  owner_nxt = 2'd0;
      S_HEAT:  owner_nxt = 2'd1;
      S_MOTOR: owner_nxt = 2'd2;
      default: owner_nxt = 2'd3;
    endcase
  end

  // State register and fairness memory
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_motor <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && state_nxt == S_HEAT)  last_motor <= 1'b0;
      if (state == S_IDLE && state_nxt == S_MOTOR) last_motor <= 1'b1;
    end
  end

  // Hold, dead-time and ramp-divider counters; all restart via IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      dead_cnt <= '0;
      ramp_cnt <= '0;
    end else begin
      if (state == S_IDLE) hold_cnt <= '0;
      else if ((state == S_HEAT || state == S_MOTOR) && hold_cnt != '1)
        hold_cnt <= hold_cnt + 1'b1;
      dead_cnt <= (state == S_DEAD) ? dead_cnt + 1'b1 : '0;
      if (state == S_IDLE) ramp_cnt <= '0;
      else if (in_motor)   ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
    end
  end

  // Registered outputs, decoded from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      heater_q <= 1'b0;
      motor_q  <= 1'b0;
      busy_q   <= 1'b0;
      owner_q  <= 2'd0;
      speed_q  <= '0;
    end else begin
      heater_q <= (state_nxt == S_HEAT);
      motor_q  <= nxt_motor;
      busy_q   <= (state_nxt != S_IDLE);
      owner_q  <= owner_nxt;
      if (!nxt_motor)     speed_q <= '0;
      else if (ramp_tick) speed_q <= speed_step;
    end
  end

endmodule

// File: tb/tb_actuator_power_arbiter.sv
// Directed bench for actuator_power_arbiter: vector table plus
// hand-written contest, fault and async-reset sequences.
module tb_actuator_power_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  actuator_power_arbiter_if #(.SPEED_W(11)) bus();

  actuator_power_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        h, m;
    logic [10:0] spd;
    logic        flt;
    int          wait_n;
    logic        eh, em;
    logic [10:0] espd;
    logic [1:0]  eown;
    logic        ebusy;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  logic overlap_seen = 1'b0;

  // Mutual-exclusion watch across the whole run
  always @(negedge clk)
    if (bus.heater_grant && bus.motor_grant) overlap_seen <= 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic h, input logic m, input logic [10:0] s, input logic f);
    bus.heater_req      = h;
    bus.motor_req       = m;
    bus.motor_speed_req = s;
    bus.fault           = f;
  endtask

  task automatic chk_all(input string tag, input logic eh, input logic em,
                         input logic [10:0] es, input logic [1:0] eo, input logic eb);
    chk({tag, ".heater_grant"},    bus.heater_grant,    eh);
    chk({tag, ".motor_grant"},     bus.motor_grant,     em);
    chk({tag, ".motor_speed_out"}, bus.motor_speed_out, es);
    chk({tag, ".owner"},           bus.owner,           eo);
    chk({tag, ".busy"},            bus.busy,            eb);
  endtask

  function automatic void add(logic h, logic m, int s, logic f, int w,
                              logic eh, logic em, int es, int eo, logic eb);
    vec_t v;
    v.h = h; v.m = m; v.spd = 11'(s); v.flt = f; v.wait_n = w;
    v.eh = eh; v.em = em; v.espd = 11'(es); v.eown = 2'(eo); v.ebusy = eb;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 11'd0, 1'b0);
    cyc(2);
    chk_all("reset", 1'b0, 1'b0, 11'd0, 2'd0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    int c, fall, rise;

    // heater alone, held 40 cycles, then dead time
    add(1,0,  0,0, 1,  1,0,  0,1,1);
    add(1,0,  0,0,39,  1,0,  0,1,1);
    add(0,0,  0,0, 1,  0,0,  0,3,1);
    add(0,0,  0,0, 7,  0,0,  0,3,1);
    add(0,0,  0,0, 1,  0,0,  0,0,0);
    // motor to 400 in 8 ticks, then ramp down to 0
    add(0,1,400,0, 1,  0,1,  0,2,1);
    add(0,1,400,0, 4,  0,1, 50,2,1);
    add(0,1,400,0, 4,  0,1,100,2,1);
    add(0,1,400,0,24,  0,1,400,2,1);
    add(0,1,400,0, 8,  0,1,400,2,1);
    add(0,0,400,0, 1,  0,1,400,3,1);
    add(0,0,400,0, 3,  0,1,350,3,1);
    add(0,0,400,0,28,  0,1,  0,3,1);
    add(0,0,400,0, 1,  0,0,  0,3,1);
    add(0,0,400,0, 8,  0,0,  0,0,0);
    // partial last step up to 120, then down to 30
    add(0,1,120,0, 1,  0,1,  0,2,1);
    add(0,1,120,0, 4,  0,1, 50,2,1);
    add(0,1,120,0, 4,  0,1,100,2,1);
    add(0,1,120,0, 4,  0,1,120,2,1);
    add(0,1,120,0, 4,  0,1,120,2,1);
    add(0,1, 30,0, 4,  0,1, 70,2,1);
    add(0,1, 30,0, 4,  0,1, 30,2,1);
    add(0,0, 30,0, 4,  0,1,  0,3,1);
    add(0,0, 30,0, 1,  0,0,  0,3,1);
    add(0,0, 30,0, 8,  0,0,  0,0,0);

    drive(1'b0, 1'b0, 11'd0, 1'b0);
    do_reset();

    foreach (vecs[i]) begin
      drive(vecs[i].h, vecs[i].m, vecs[i].spd, vecs[i].flt);
      cyc(vecs[i].wait_n);
      chk_all($sformatf("vec%0d", i), vecs[i].eh, vecs[i].em,
              vecs[i].espd, vecs[i].eown, vecs[i].ebusy);
    end

    // Contest right after reset: heater first, pre-empted after MAX_HOLD
    do_reset();
    drive(1'b1, 1'b1, 11'd0, 1'b0);
    cyc(1);
    chk("contest.first_heater", bus.heater_grant, 1'b1);
    chk("contest.first_motor",  bus.motor_grant,  1'b0);
    c = 1; fall = -1; rise = -1;
    for (int i = 0; i < 1100 && rise < 0; i++) begin
      cyc(1);
      c++;
      if (fall < 0 && !bus.heater_grant) fall = c;
      if (rise < 0 && bus.motor_grant)   rise = c;
    end
    chk("contest.heater_release_cycle", fall, 1026);
    chk("contest.motor_grant_cycle",    rise, 1035);
    drive(1'b0, 1'b0, 11'd0, 1'b0);
    cyc(60);
    chk_all("contest.idle", 1'b0, 1'b0, 11'd0, 2'd0, 1'b0);

    // Fault below MIN_ON, fault blocks new grants, release re-arbitrates
    drive(1'b1, 1'b0, 11'd0, 1'b0);
    cyc(1);
    chk("fault.heater_on", bus.heater_grant, 1'b1);
    cyc(4);
    chk("fault.heater_c5", bus.heater_grant, 1'b1);
    bus.fault = 1'b1;
    cyc(1);
    chk_all("fault.cut", 1'b0, 1'b0, 11'd0, 2'd3, 1'b1);
    cyc(8);
    chk_all("fault.idle", 1'b0, 1'b0, 11'd0, 2'd0, 1'b0);
    bus.motor_req = 1'b1;
    cyc(5);
    chk_all("fault.blocked", 1'b0, 1'b0, 11'd0, 2'd0, 1'b0);
    bus.fault = 1'b0;
    cyc(1);
    chk_all("fault.rearb_motor", 1'b0, 1'b1, 11'd0, 2'd2, 1'b1);
    drive(1'b0, 1'b0, 11'd0, 1'b0);
    cyc(40);
    chk_all("fault.done", 1'b0, 1'b0, 11'd0, 2'd0, 1'b0);

    // Asynchronous reset at speed 300, then heater wins first contest
    drive(1'b0, 1'b1, 11'd400, 1'b0);
    cyc(1);
    chk("areset.motor_on", bus.motor_grant, 1'b1);
    cyc(24);
    chk("areset.speed300", bus.motor_speed_out, 11'd300);
    reset_n = 1'b0;
    #2;
    chk_all("areset.async", 1'b0, 1'b0, 11'd0, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 11'd0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1);
    chk_all("areset.heater_first", 1'b1, 1'b0, 11'd0, 2'd1, 1'b1);

    chk("no_overlap", overlap_seen, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
